// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// Memory-access stage of a five-stage RV32I pipeline. It takes the EX/MEM
// fields and performs byte, half and word loads and stores over a single
// req/ack data-memory port. It also registers the MEM/WB fields that feed
// write-back. While a bus transaction is outstanding it holds the upstream
// stages with mem_stall.
//
// Ports
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   ex_*                       instruction fields presented by EX/MEM
//   mem_stall                  combinational hold request for earlier stages
//   dmem_req/we/addr/wdata/be  registered data-memory request fields
//   dmem_rdata, dmem_ack       memory response (rdata valid while ack = 1)
//   wb_*                       registered MEM/WB outputs
//   align_err, bus_err         one-cycle error pulses, aligned with wb_valid
// Parameter
//   ACK_TIMEOUT                ACCESS cycles without ack before the access is
//                              aborted; 0 disables the timeout
// -----------------------------------------------------------------------------
module mem_access_stage #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_mem_to_reg,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_mem_data,
  output logic        wb_mem_to_reg,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        align_err,
  output logic        bus_err
);

  typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(ACK_TIMEOUT);

  state_t      state;
  state_t      state_next;

  // Fields of the access in flight, captured when it leaves IDLE.
  logic [31:0] lat_addr;
  logic [2:0]  lat_funct3;
  logic        lat_store;
  logic [4:0]  lat_rd;
  logic        lat_reg_write;
  logic        lat_mem_to_reg;
  logic [15:0] cnt;
  logic [15:0] cnt_inc;

  logic        funct3_legal;
  logic        is_mem;
  logic        op_ok;
  logic        start_ok;
  logic        start_bad;
  logic        timeout_hit;
  logic        finish;

  // Halfwords need addr[0] = 0 and words need addr[1:0] = 0.
  // funct3[1:0] = 11 has no legal size.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = off[0];
      2'b10:   is_misaligned = (off != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   byte_enables = 4'b0001 << off;
      2'b01:   byte_enables = 4'b0011 << off;
      default: byte_enables = 4'b1111;
    endcase
  endfunction

  // The store datum is replicated on every lane, and the byte enables pick
  // the lanes that are written.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] data);
    case (f3[1:0])
      2'b00:   store_lanes = {4{data[7:0]}};
      2'b01:   store_lanes = {2{data[15:0]}};
      default: store_lanes = data;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then sign- or zero-extend it.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rdata);
    logic [31:0] shifted;
    shifted = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  load_extend = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_extend = {24'h000000, shifted[7:0]};
      3'b001:  load_extend = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_extend = {16'h0000, shifted[15:0]};
      default: load_extend = rdata;
    endcase
  endfunction

  // Decide whether funct3 is a legal size code for the requested direction.
  always_comb begin
    funct3_legal = 1'b0;
    case (ex_funct3)
      3'b000, 3'b001, 3'b010: funct3_legal = 1'b1;
      3'b100, 3'b101:         funct3_legal = ~ex_mem_write;
      default:                funct3_legal = 1'b0;
    endcase
  end

  assign is_mem    = ex_mem_read | ex_mem_write;
  assign op_ok     = is_mem & ~(ex_mem_read & ex_mem_write) & funct3_legal &
                     ~is_misaligned(ex_funct3, ex_alu_result[1:0]);
  assign start_ok  = ex_valid & op_ok;
  assign start_bad = ex_valid & is_mem & ~op_ok;

  // The count has reached the limit in the cycle where it would step onto
  // ACK_TIMEOUT. An ack in that same cycle still wins.
  assign cnt_inc     = cnt + 16'd1;
  assign timeout_hit = (state == ACCESS) & ~dmem_ack & (TIMEOUT_LIMIT != 16'd0) &
                       (cnt_inc == TIMEOUT_LIMIT);
  assign finish      = dmem_ack | timeout_hit;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_next = ACCESS;
        end else begin
          state_next = IDLE;
        end
      end
      ACCESS: begin
        if (finish) begin
          state_next = IDLE;
        end else begin
          state_next = ACCESS;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Stall output. The stall drops in the cycle that ends an access, so that
  // upstream advances on that edge.
  always_comb begin
    mem_stall = 1'b0;
    if (rst) begin
      mem_stall = 1'b0;
    end else if (state == IDLE) begin
      mem_stall = start_ok;
    end else begin
      mem_stall = ~finish;
    end
  end

  // Bus request, latched access fields, timeout counter and MEM/WB register.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= 32'h0;
      dmem_wdata     <= 32'h0;
      dmem_be        <= 4'h0;
      lat_addr       <= 32'h0;
      lat_funct3     <= 3'b000;
      lat_store      <= 1'b0;
      lat_rd         <= 5'd0;
      lat_reg_write  <= 1'b0;
      lat_mem_to_reg <= 1'b0;
      cnt            <= 16'd0;
      wb_valid       <= 1'b0;
      wb_alu_result  <= 32'h0;
      wb_mem_data    <= 32'h0;
      wb_mem_to_reg  <= 1'b0;
      wb_rd          <= 5'd0;
      wb_reg_write   <= 1'b0;
      align_err      <= 1'b0;
      bus_err        <= 1'b0;
    end else begin
      align_err <= 1'b0;
      bus_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            lat_addr       <= ex_alu_result;
            lat_funct3     <= ex_funct3;
            lat_store      <= ex_mem_write;
            lat_rd         <= ex_rd;
            lat_reg_write  <= ex_reg_write;
            lat_mem_to_reg <= ex_mem_to_reg;
            cnt            <= 16'd0;
            dmem_req       <= 1'b1;
            dmem_we        <= ex_mem_write;
            dmem_addr      <= {ex_alu_result[31:2], 2'b00};
            dmem_be        <= byte_enables(ex_funct3, ex_alu_result[1:0]);
            dmem_wdata     <= store_lanes(ex_funct3, ex_store_data);
            wb_valid       <= 1'b0;
            wb_reg_write   <= 1'b0;
            wb_mem_data    <= 32'h0;
          end else begin
            // This branch covers an ALU op, a bubble, or a rejected memory
            // op. A rejected op retires without writing a register.
            wb_valid      <= ex_valid;
            wb_alu_result <= ex_alu_result;
            wb_rd         <= ex_rd;
            wb_mem_to_reg <= ex_mem_to_reg;
            wb_mem_data   <= 32'h0;
            wb_reg_write  <= ex_valid & ex_reg_write & ~start_bad;
            align_err     <= start_bad;
          end
        end
        ACCESS: begin
          if (finish) begin
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            wb_valid      <= 1'b1;
            wb_alu_result <= lat_addr;
            wb_rd         <= lat_rd;
            wb_mem_to_reg <= lat_mem_to_reg;
            wb_reg_write  <= dmem_ack & lat_reg_write & ~lat_store;
            if (dmem_ack & ~lat_store) begin
              wb_mem_data <= load_extend(lat_funct3, lat_addr[1:0], dmem_rdata);
            end else begin
              wb_mem_data <= 32'h0;
            end
            bus_err       <= ~dmem_ack;
          end else begin
            cnt          <= cnt_inc;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
          end
        end
        default: begin
          dmem_req     <= 1'b0;
          wb_valid     <= 1'b0;
          wb_reg_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_to_reg;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [2:0]  ex_funct3;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        wb_valid;
  logic [31:0] wb_alu_result;
  logic [31:0] wb_mem_data;
  logic        wb_mem_to_reg;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        align_err;
  logic        bus_err;

  int compared = 0;
  int mismatched = 0;

  mem_access_stage #(.ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
    .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_valid(wb_valid), .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .align_err(align_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".stall"}, 32'(mem_stall), 32'h0);
    check({tag, ".req"}, 32'(dmem_req), 32'h0);
    check({tag, ".we"}, 32'(dmem_we), 32'h0);
    check({tag, ".addr"}, dmem_addr, 32'h0);
    check({tag, ".wdata"}, dmem_wdata, 32'h0);
    check({tag, ".be"}, 32'(dmem_be), 32'h0);
    check({tag, ".wb_valid"}, 32'(wb_valid), 32'h0);
    check({tag, ".wb_alu"}, wb_alu_result, 32'h0);
    check({tag, ".wb_data"}, wb_mem_data, 32'h0);
    check({tag, ".wb_m2r"}, 32'(wb_mem_to_reg), 32'h0);
    check({tag, ".wb_rd"}, 32'(wb_rd), 32'h0);
    check({tag, ".wb_rw"}, 32'(wb_reg_write), 32'h0);
    check({tag, ".align_err"}, 32'(align_err), 32'h0);
    check({tag, ".bus_err"}, 32'(bus_err), 32'h0);
  endtask

  // Present one instruction, act as the memory (ack in ACCESS cycle k, or
  // never when k = 0), and check the stage against the reference model.
  // The task returns in the cycle where the result is visible on wb_*,
  // with ex_valid already dropped.
  task automatic run_op(input string tag, input logic rd_en, input logic wr_en,
                        input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [31:0] rdata,
                        input int k, input logic [4:0] rd, input logic rw);
    bit          is_mem, legal, timed_out;
    int          nbytes, off, bits;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_load, exp_data;
    longint      v;

    // Reference model: legality, lanes and extension from the ISA rules.
    is_mem = rd_en || wr_en;
    nbytes = 1 << f3[1:0];
    off    = int'(addr % 32'd4);
    legal  = (rd_en != wr_en) &&
             ((f3 inside {3'd0, 3'd1, 3'd2}) || (rd_en && (f3 inside {3'd4, 3'd5}))) &&
             (addr % nbytes == 0);
    for (int i = 0; i < 4; i++) begin
      exp_be[i] = (i >= off) && (i < off + nbytes);
      exp_wdata[8*i +: 8] = sdata[8*(i % nbytes) +: 8];
    end
    if (nbytes >= 4) begin
      exp_load = rdata;
    end else begin
      bits = 8 * nbytes;
      v = 0;
      v[31:0] = rdata >> (8 * off);
      v = v % (longint'(1) << bits);
      if (!f3[2] && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
      exp_load = v[31:0];
    end

    ex_valid = 1'b1; ex_alu_result = addr; ex_store_data = sdata; ex_rd = rd;
    ex_reg_write = rw; ex_mem_to_reg = rd_en; ex_mem_read = rd_en; ex_mem_write = wr_en;
    ex_funct3 = f3;
    #1;
    check({tag, ".stall0"}, 32'(mem_stall), 32'(is_mem && legal));
    check({tag, ".req0"}, 32'(dmem_req), 32'h0);

    if (!is_mem || !legal) begin
      tick;
      ex_valid = 1'b0;
      check({tag, ".wb_valid"}, 32'(wb_valid), 32'h1);
      check({tag, ".wb_rw"}, 32'(wb_reg_write), 32'(!is_mem && rw));
      check({tag, ".wb_alu"}, wb_alu_result, addr);
      check({tag, ".wb_rd"}, 32'(wb_rd), 32'(rd));
      check({tag, ".wb_data"}, wb_mem_data, 32'h0);
      check({tag, ".align_err"}, 32'(align_err), 32'(is_mem));
      check({tag, ".req"}, 32'(dmem_req), 32'h0);
      return;
    end

    timed_out = 1'b1;
    for (int j = 1; j <= TMO; j++) begin
      tick;
      check({tag, ".req"}, 32'(dmem_req), 32'h1);
      check({tag, ".wb_idle"}, 32'(wb_valid), 32'h0);
      if (j == 1) begin
        check({tag, ".addr"}, dmem_addr, addr & 32'hFFFF_FFFC);
        check({tag, ".be"}, 32'(dmem_be), 32'(exp_be));
        check({tag, ".we"}, 32'(dmem_we), 32'(wr_en));
        if (wr_en) check({tag, ".wdata"}, dmem_wdata, exp_wdata);
      end
      if (j == k) begin
        dmem_ack = 1'b1;
        dmem_rdata = rdata;
        #1;
        check({tag, ".stall_ack"}, 32'(mem_stall), 32'h0);
        timed_out = 1'b0;
        break;
      end else if (j < TMO) begin
        check({tag, ".stall_wait"}, 32'(mem_stall), 32'h1);
      end
    end

    tick;
    dmem_ack = 1'b0;
    dmem_rdata = $urandom;
    ex_valid = 1'b0;
    exp_data = (wr_en || timed_out) ? 32'h0 : exp_load;
    check({tag, ".wb_valid"}, 32'(wb_valid), 32'h1);
    check({tag, ".wb_rw"}, 32'(wb_reg_write), 32'(rw && !wr_en && !timed_out));
    if (!timed_out) check({tag, ".wb_data"}, wb_mem_data, exp_data);
    check({tag, ".wb_rd"}, 32'(wb_rd), 32'(rd));
    check({tag, ".wb_m2r"}, 32'(wb_mem_to_reg), 32'(rd_en));
    check({tag, ".bus_err"}, 32'(bus_err), 32'(timed_out));
    check({tag, ".align_err"}, 32'(align_err), 32'h0);
    check({tag, ".req_drop"}, 32'(dmem_req), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r_addr, r_data, r_sdata;
    int          sel, k;
    logic [2:0]  f3;

    rst = 1'b1; ex_valid = 1'b0; ex_alu_result = 32'h0; ex_store_data = 32'h0; ex_rd = 5'd0;
    ex_reg_write = 1'b0; ex_mem_to_reg = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    ex_funct3 = 3'b000; dmem_rdata = 32'h0; dmem_ack = 1'b0;
    tick;
    tick;
    check_all_zero("reset");
    rst = 1'b0;

    // Directed cases.
    run_op("lw_ack1", 1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1, 5'd5, 1'b1);
    run_op("lb_ack3", 1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h8012_3456, 3, 5'd6, 1'b1);
    run_op("lbu_ack3", 1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h8012_3456, 3, 5'd7, 1'b1);
    run_op("sh", 1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 32'h0, 1, 5'd8, 1'b0);
    run_op("lw_misal", 1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h0, 1, 5'd9, 1'b1);
    run_op("f3_011", 1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 1, 5'd10, 1'b1);
    run_op("timeout", 1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'h1234_5678, 0, 5'd11, 1'b1);
    run_op("ack_at_tmo", 1'b1, 1'b0, 3'b010, 32'h0000_0204, 32'h0, 32'h1234_5678, TMO, 5'd12, 1'b1);

    // Bubble: nothing presented, nothing retires.
    tick;
    check("bubble.wb_valid", 32'(wb_valid), 32'h0);
    check("bubble.wb_rw", 32'(wb_reg_write), 32'h0);

    // Reset in the middle of an access; a late ack must be ignored.
    ex_valid = 1'b1; ex_alu_result = 32'h0000_0300; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
    ex_funct3 = 3'b010; ex_rd = 5'd3; ex_reg_write = 1'b1; ex_mem_to_reg = 1'b1;
    tick;
    check("rst_mid.req", 32'(dmem_req), 32'h1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    ex_valid = 1'b0;
    check_all_zero("rst_mid");
    dmem_ack = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    #1;
    check("late_ack.stall", 32'(mem_stall), 32'h0);
    tick;
    dmem_ack = 1'b0;
    check("late_ack.wb_valid", 32'(wb_valid), 32'h0);
    check("late_ack.req", 32'(dmem_req), 32'h0);

    // Three back-to-back ALU ops.
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_mem_to_reg = 1'b0; ex_reg_write = 1'b1;
    ex_valid = 1'b1; ex_alu_result = 32'h1111_0000; ex_rd = 5'd1;
    #1;
    check("alu0.stall", 32'(mem_stall), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      tick;
      check("alu.wb_valid", 32'(wb_valid), 32'h1);
      check("alu.wb_alu", wb_alu_result, 32'h1111_0000 + 32'(i - 1));
      check("alu.wb_rd", 32'(wb_rd), 32'(i));
      check("alu.wb_rw", 32'(wb_reg_write), 32'h1);
      if (i < 3) begin
        ex_alu_result = 32'h1111_0000 + 32'(i);
        ex_rd = 5'(i + 1);
      end else begin
        ex_valid = 1'b0;
      end
      #1;
      check("alu.stall", 32'(mem_stall), 32'h0);
    end

    // Randomized mix checked against the model.
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      f3 = 3'($urandom_range(0, 7));
      r_addr = $urandom;
      r_data = $urandom;
      r_sdata = $urandom;
      k = $urandom_range(0, TMO);
      if (sel <= 4) begin
        run_op("rnd_ld", 1'b1, 1'b0, f3, r_addr, r_sdata, r_data, k, 5'($urandom_range(0, 31)), 1'b1);
      end else if (sel <= 7) begin
        run_op("rnd_st", 1'b0, 1'b1, f3, r_addr, r_sdata, r_data, k, 5'($urandom_range(0, 31)), 1'b0);
      end else if (sel == 8) begin
        run_op("rnd_both", 1'b1, 1'b1, f3, r_addr, r_sdata, r_data, k, 5'($urandom_range(0, 31)), 1'b1);
      end else begin
        run_op("rnd_alu", 1'b0, 1'b0, f3, r_addr, r_sdata, r_data, k, 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)));
      end
    end

    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the five-stage RISC-V core. It sits between the EX/MEM boundary and the write-back mux, and performs RV32I loads and stores over a req/ack data-memory port. It handles byte/half/word alignment, byte enables and load extension, and registers the MEM/WB pipeline outputs that feed write-back. It holds the pipeline with `mem_stall` while a memory transaction is outstanding.

## Interface
- `ACK_TIMEOUT`, default 255: cycles in ACCESS without `dmem_ack` before the access is aborted; 0 disables the timeout.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ex_valid` in 1: an instruction is presented by EX/MEM.
- `ex_alu_result` in 32: ALU result, or the effective address for memory ops.
- `ex_store_data` in 32: rs2 value for stores.
- `ex_rd` in 5, `ex_reg_write` in 1, `ex_mem_to_reg` in 1: write-back controls.
- `ex_mem_read` in 1, `ex_mem_write` in 1: load / store.
- `ex_funct3` in 3: access size and sign.
- `mem_stall` out 1: hold EX/MEM and earlier stages; combinational.
- `dmem_req` out 1, `dmem_we` out 1: request and write strobe.
- `dmem_addr` out 32: word-aligned address, with `[1:0]` = 0.
- `dmem_wdata` out 32, `dmem_be` out 4: lane-replicated store data and byte enables.
- `dmem_rdata` in 32, `dmem_ack` in 1: read data, valid in the cycle `dmem_ack` = 1.
- `wb_valid` out 1, `wb_alu_result` out 32, `wb_mem_data` out 32, `wb_mem_to_reg` out 1, `wb_rd` out 5, `wb_reg_write` out 1: MEM/WB register outputs.
- `align_err` out 1, `bus_err` out 1: one-cycle error pulses.

## Operation
- **States:** IDLE and ACCESS.
- **funct3 decode:**
  - 000 → LB/SB
  - 001 → LH/SH
  - 010 → LW/SW
  - 100 → LBU
  - 101 → LHU
  - Any other code, or 100/101 on a store, is illegal.
- **Alignment:** a halfword requires `addr[0]` = 0; a word requires `addr[1:0]` = 0.
- **IDLE, no memory op:**
  - `ex_valid` with neither `ex_mem_read` nor `ex_mem_write`: the MEM/WB register loads the `ex_*` fields with `wb_valid` = 1 and `wb_mem_data` = 0.
  - `ex_valid` = 0: the register loads a bubble (`wb_valid` = 0, `wb_reg_write` = 0).
- **IDLE, legal aligned memory op:**
  - `mem_stall` = 1.
  - Latch address, op, size, sign, `rd` and `ex_reg_write`.
  - Drive `dmem_req`/`dmem_we`/`dmem_addr`/`dmem_be`/`dmem_wdata` as registered outputs.
  - Next state ACCESS; MEM/WB loads a bubble.
- **Illegal, misaligned, or both read and write set:**
  - No bus request.
  - `align_err` pulses 1 on the next cycle.
  - MEM/WB loads `wb_valid` = 1 and `wb_reg_write` = 0.
  - No stall; stay in IDLE.
- **Byte enables:**
  - Byte: `dmem_be` = 1 << `addr[1:0]`.
  - Half: `dmem_be` = 4'b0011 << `addr[1:0]`.
  - Word: `dmem_be` = 4'b1111.
  - Loads drive the same `dmem_be`.
- **Store data:**
  - Byte: `{4{store[7:0]}}`.
  - Half: `{2{store[15:0]}}`.
  - Word: unchanged.
- **ACCESS:**
  - `dmem_req` and all bus fields are held stable.
  - The `ex_*` inputs are ignored; they carry the same held instruction.
  - `mem_stall` = 1 until the ack cycle, where it is 0.
- **ACCESS, `dmem_ack` = 1:**
  - Select the byte or half from `dmem_rdata` by `addr[1:0]`, then sign-extend (LB/LH) or zero-extend (LBU/LHU) into `wb_mem_data`.
  - MEM/WB loads the latched fields with `wb_valid` = 1.
  - Stores load `wb_reg_write` = 0 and `wb_mem_data` = 0.
  - `dmem_req` drops at the same edge; next state IDLE.
- **Timeout:**
  - A 16-bit counter clears on entry to ACCESS and increments each cycle without ack.
  - When it equals `ACK_TIMEOUT` (nonzero): abort, drop `dmem_req`, pulse `bus_err`, load MEM/WB with `wb_valid` = 1 and `wb_reg_write` = 0, and return to IDLE.
  - An ack arriving in the same cycle the count is reached wins: the access completes normally.
- **Reset:**
  - State IDLE; counter 0.
  - Every output is 0: `dmem_*`, `wb_*`, `align_err`, `bus_err`, and `mem_stall` (since IDLE and `ex_valid` is ignored).
  - Reset during ACCESS drops `dmem_req` at that edge with no `wb_valid`; a late ack is ignored.

## Timing
- Non-memory op: `wb_*` valid 1 cycle after presentation; no stall.
- Memory op, ack in the k-th ACCESS cycle (k ≥ 1):
  - `dmem_req` high from cycle 1 to cycle k.
  - `mem_stall` high for cycles 0..k-1 (cycle 0 = presentation).
  - `wb_valid` at cycle k+1.
  - Minimum load-to-WB latency is 2 cycles.
- Upstream advances on the edge that ends the ack cycle. The instruction presented in the following cycle is a new one and is evaluated from IDLE.
- `dmem_req` never rises in the same cycle `dmem_ack` is sampled, and there is at most one outstanding request.
- Error pulses last exactly one cycle, aligned with the corresponding `wb_valid`.

## Test plan
- **LW, ack in first ACCESS cycle:** LW at 0x100, `dmem_rdata` = 0xDEADBEEF → `dmem_be` = 1111; `mem_stall` 1 for 1 cycle; `wb_mem_data` = 0xDEADBEEF; `wb_valid` 2 cycles after presentation.
- **LB vs LBU, ack after 3 cycles:** LB at 0x103, `dmem_rdata` = 0x80123456 → `dmem_be` = 1000, `wb_mem_data` = 0xFFFFFF80. LBU at the same address → 0x00000080. `mem_stall` high for 3 cycles.
- **SH:** SH at 0x102, store data 0x0000ABCD → `dmem_we` = 1, `dmem_be` = 1100, `dmem_wdata` = 0xABCDABCD, `dmem_addr` = 0x100, `wb_reg_write` = 0.
- **Misaligned LW:** LW at 0x101 → no `dmem_req`, `align_err` pulse, `wb_valid` = 1 with `wb_reg_write` = 0, no stall. Same response for funct3 = 011.
- **Timeout:** `ACK_TIMEOUT` = 4, ack never given → `dmem_req` drops after 4 ACCESS cycles, `bus_err` pulse, `wb_reg_write` = 0. With ack in the 4th cycle instead → normal completion, no `bus_err`.
- **Reset mid-access, then back-to-back ALU ops:** `rst` during ACCESS → next cycle all outputs 0; a following ack is ignored. Three back-to-back ALU ops → three consecutive `wb_valid` cycles carrying their `ex_alu_result`/`ex_rd` values, with `mem_stall` never asserted.
